// File: rtl/soc_pkg.sv
// ============================================================================
//  soc_pkg
//  Shared FSM state encodings and RAM geometry for the data-RAM arbiter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package soc_pkg;

   localparam int RAM_ADDR_W = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/arb_rr2.sv
// ============================================================================
//  arb_rr2
//  Two-way request to one-hot grant; round-robin on last owner or fixed priority.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module arb_rr2 #(
   parameter int RR_EN = 1
) (
   input  logic [1:0] req,
   input  logic       last_owner,
   output logic [1:0] grant
);

   // On a tie, round-robin hands the grant to the port that did not own the last one.
   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = ((RR_EN != 0) && !last_owner) ? 2'b10 : 2'b01;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ram_arb_ctrl.sv
// ============================================================================
//  ram_arb_ctrl
//  Two-port arbiter/sequencer for a single-port synchronous block data RAM.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module ram_arb_ctrl
   import soc_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1,
   parameter int RR_EN  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_ready,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_ready,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              owner,
   output logic              busy
);

   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       grant;

   arb_rr2 #(
      .RR_EN (RR_EN)
   ) u_arb (
      .req        ({m1_req, m0_req}),
      .last_owner (owner),
      .grant      (grant)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         ram_we   <= 1'b0;
         ram_addr <= '0;
         ram_din  <= '0;
         m0_rdata <= '0;
         m1_rdata <= '0;
         m0_ready <= 1'b0;
         m1_ready <= 1'b0;
         owner    <= 1'b1;
         busy     <= 1'b0;
      end else begin
         m0_ready <= 1'b0;
         m1_ready <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant[1]) begin
                  owner    <= 1'b1;
                  ram_we   <= m1_we;
                  ram_addr <= m1_addr;
                  ram_din  <= m1_wdata;
                  busy     <= 1'b1;
                  state    <= ST_ISSUE;
               end else if (grant[0]) begin
                  owner    <= 1'b0;
                  ram_we   <= m0_we;
                  ram_addr <= m0_addr;
                  ram_din  <= m0_wdata;
                  busy     <= 1'b1;
                  state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // ram_we still holds the granted direction during this cycle.
               ram_we <= 1'b0;
               if (ram_we) begin
                  state <= ST_DONE;
               end else begin
                  cnt   <= CNT_W'(RD_LAT - 1);
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt == '0) begin
                  if (owner) m1_rdata <= ram_dout;
                  else       m0_rdata <= ram_dout;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DONE: begin
               if (owner) m1_ready <= 1'b1;
               else       m0_ready <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               ram_we <= 1'b0;
               busy   <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ram_arb_ctrl.sv
// ============================================================================
//  tb_ram_arb_ctrl
//  Directed bench: three arbiter instances (RR/lat1, RR/lat3, fixed/lat1) on shared inputs.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ram_arb_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
   logic [9:0]  m0_addr = '0, m1_addr = '0;
   logic [31:0] m0_wdata = '0, m1_wdata = '0;

   logic [31:0] m0_rdata [3];
   logic [31:0] m1_rdata [3];
   logic [31:0] ram_din  [3];
   logic [31:0] ram_dout [3];
   logic [9:0]  ram_addr [3];
   logic        m0_ready [3];
   logic        m1_ready [3];
   logic        ram_we   [3];
   logic        owner    [3];
   logic        busy     [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ram_arb_ctrl #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1), .RR_EN(1)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_rdata(m0_rdata[0]), .m0_ready(m0_ready[0]),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_rdata(m1_rdata[0]), .m1_ready(m1_ready[0]),
      .ram_we(ram_we[0]), .ram_addr(ram_addr[0]), .ram_din(ram_din[0]), .ram_dout(ram_dout[0]),
      .owner(owner[0]), .busy(busy[0])
   );

   ram_arb_ctrl #(.ADDR_W(10), .DATA_W(32), .RD_LAT(3), .RR_EN(1)) dut_l3 (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_rdata(m0_rdata[1]), .m0_ready(m0_ready[1]),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_rdata(m1_rdata[1]), .m1_ready(m1_ready[1]),
      .ram_we(ram_we[1]), .ram_addr(ram_addr[1]), .ram_din(ram_din[1]), .ram_dout(ram_dout[1]),
      .owner(owner[1]), .busy(busy[1])
   );

   ram_arb_ctrl #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1), .RR_EN(0)) dut_fp (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_rdata(m0_rdata[2]), .m0_ready(m0_ready[2]),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_rdata(m1_rdata[2]), .m1_ready(m1_ready[2]),
      .ram_we(ram_we[2]), .ram_addr(ram_addr[2]), .ram_din(ram_din[2]), .ram_dout(ram_dout[2]),
      .owner(owner[2]), .busy(busy[2])
   );

   // Synchronous RAM model per instance; dout valid LAT edges after the address.
   for (genvar g = 0; g < 3; g++) begin : g_ram
      localparam int LAT = (g == 1) ? 3 : 1;
      logic [31:0] mem  [1024];
      logic [31:0] pipe [LAT];
      always @(posedge clk) begin
         if (ram_we[g]) mem[ram_addr[g]] <= ram_din[g];
         pipe[0] <= mem[ram_addr[g]];
         for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
      assign ram_dout[g] = pipe[LAT-1];
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m0_req = 1'b0; m1_req = 1'b0;
      step(2);
      rst = 1'b0;
      step(1);
   endtask

   task automatic xact(input bit port, input bit we, input logic [9:0] a, input logic [31:0] d);
      if (port) begin m1_we = we; m1_addr = a; m1_wdata = d; m1_req = 1'b1; end
      else      begin m0_we = we; m0_addr = a; m0_wdata = d; m0_req = 1'b1; end
      step(1);
      m0_req = 1'b0; m1_req = 1'b0;
      step(6);
   endtask

   task automatic test_reset();
      do_reset();
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({ram_we[d], ram_addr[d], ram_din[d], owner[d], busy[d], m0_ready[d], m1_ready[d],
              m0_rdata[d], m1_rdata[d]} !==
             {1'b0, 10'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_state[%0d]: we=%b addr=%h din=%h own=%b busy=%b rdy=%b%b rd0=%h rd1=%h, want own=1 rest 0",
                     d, ram_we[d], ram_addr[d], ram_din[d], owner[d], busy[d], m0_ready[d], m1_ready[d],
                     m0_rdata[d], m1_rdata[d]);
         end
      end
   endtask

   task automatic test_write();
      do_reset();
      m0_we = 1'b1; m0_addr = 10'h005; m0_wdata = 32'hDEADBEEF; m0_req = 1'b1;
      step(1);
      m0_req = 1'b0;
      checks++; if ({ram_we[0], ram_addr[0], ram_din[0]} !== {1'b1, 10'h005, 32'hDEADBEEF}) begin
         errors++; $display("FAIL wr_issue: we=%b addr=%h din=%h, want 1 005 deadbeef", ram_we[0], ram_addr[0], ram_din[0]); end
      checks++; if ({owner[0], busy[0]} !== 2'b01) begin
         errors++; $display("FAIL wr_owner_busy: %b%b, want 01", owner[0], busy[0]); end
      step(1);
      checks++; if ({ram_we[0], m0_ready[0]} !== 2'b00) begin
         errors++; $display("FAIL wr_after_issue: we=%b rdy=%b, want 0 0", ram_we[0], m0_ready[0]); end
      step(1);
      checks++; if ({m0_ready[0], m1_ready[0]} !== 2'b10) begin
         errors++; $display("FAIL wr_ready: m0=%b m1=%b, want 1 0", m0_ready[0], m1_ready[0]); end
      step(1);
      checks++; if ({m0_ready[0], busy[0]} !== 2'b00) begin
         errors++; $display("FAIL wr_ready_pulse: rdy=%b busy=%b, want 0 0", m0_ready[0], busy[0]); end
   endtask

   task automatic test_read();
      do_reset();
      m1_we = 1'b0; m1_addr = 10'h005; m1_req = 1'b1;
      step(1);
      m1_req = 1'b0;
      checks++; if ({owner[0], ram_we[0], ram_addr[0]} !== {1'b1, 1'b0, 10'h005}) begin
         errors++; $display("FAIL rd_issue: own=%b we=%b addr=%h, want 1 0 005", owner[0], ram_we[0], ram_addr[0]); end
      step(2);
      checks++; if (m1_ready[0] !== 1'b0) begin
         errors++; $display("FAIL rd_early: m1_ready=%b, want 0", m1_ready[0]); end
      step(1);
      checks++; if ({m1_ready[0], m1_rdata[0]} !== {1'b1, 32'hDEADBEEF}) begin
         errors++; $display("FAIL rd_lat1: rdy=%b data=%h, want 1 deadbeef", m1_ready[0], m1_rdata[0]); end
      checks++; if ({m0_ready[0], m0_rdata[0], m1_ready[1]} !== {1'b0, 32'h0, 1'b0}) begin
         errors++; $display("FAIL rd_other: m0rdy=%b m0data=%h l3rdy=%b, want 0 0 0", m0_ready[0], m0_rdata[0], m1_ready[1]); end
      step(1);
      checks++; if ({m1_ready[1], m1_ready[0], m1_rdata[0]} !== {1'b0, 1'b0, 32'hDEADBEEF}) begin
         errors++; $display("FAIL rd_hold: l3rdy=%b rdy=%b data=%h, want 0 0 deadbeef", m1_ready[1], m1_ready[0], m1_rdata[0]); end
      step(1);
      checks++; if ({m1_ready[1], m1_rdata[1]} !== {1'b1, 32'hDEADBEEF}) begin
         errors++; $display("FAIL rd_lat3: rdy=%b data=%h, want 1 deadbeef", m1_ready[1], m1_rdata[1]); end
      step(2);
   endtask

   task automatic test_contention();
      logic [9:0] exp_addr;
      do_reset();
      m0_we = 1'b1; m0_addr = 10'h010; m0_wdata = 32'h11110000;
      m1_we = 1'b1; m1_addr = 10'h020; m1_wdata = 32'h22220000;
      m0_req = 1'b1; m1_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1);
         exp_addr = (i % 2 == 1) ? 10'h020 : 10'h010;
         checks++; if ({owner[0], ram_addr[0]} !== {(i % 2 == 1), exp_addr}) begin
            errors++; $display("FAIL rr_grant[%0d]: own=%b addr=%h, want %0d %h", i, owner[0], ram_addr[0], i % 2, exp_addr); end
         checks++; if ({owner[2], ram_addr[2]} !== {1'b0, 10'h010}) begin
            errors++; $display("FAIL fp_grant[%0d]: own=%b addr=%h, want 0 010", i, owner[2], ram_addr[2]); end
         step(2);
         checks++; if ({m0_ready[0], m1_ready[0]} !== ((i % 2 == 1) ? 2'b01 : 2'b10)) begin
            errors++; $display("FAIL rr_ready[%0d]: m0=%b m1=%b, want port %0d", i, m0_ready[0], m1_ready[0], i % 2); end
      end
      m0_req = 1'b0;
      step(1);
      checks++; if ({owner[2], ram_addr[2], owner[0]} !== {1'b1, 10'h020, 1'b1}) begin
         errors++; $display("FAIL fp_m1_alone: own=%b addr=%h rr_own=%b, want 1 020 1", owner[2], ram_addr[2], owner[0]); end
      m1_req = 1'b0;
      step(2);
      checks++; if ({m1_ready[2], m0_ready[2]} !== 2'b10) begin
         errors++; $display("FAIL fp_m1_ready: m1=%b m0=%b, want 1 0", m1_ready[2], m0_ready[2]); end
      step(2);
   endtask

   task automatic test_withdraw();
      do_reset();
      m0_we = 1'b0; m0_addr = 10'h005; m0_req = 1'b1;
      step(1);
      m0_req = 1'b0; m0_addr = 10'h010;
      step(3);
      checks++; if ({m0_ready[0], m0_rdata[0]} !== {1'b1, 32'hDEADBEEF}) begin
         errors++; $display("FAIL wd_ready: rdy=%b data=%h, want 1 deadbeef", m0_ready[0], m0_rdata[0]); end
      step(1);
      checks++; if ({m0_ready[0], busy[0]} !== 2'b00) begin
         errors++; $display("FAIL wd_no_regrant: rdy=%b busy=%b, want 0 0", m0_ready[0], busy[0]); end
   endtask

   task automatic test_reset_midop();
      do_reset();
      xact(1'b0, 1'b1, 10'h033, 32'h55AA55AA);
      m0_we = 1'b1; m0_addr = 10'h033; m0_wdata = 32'h12345678; m0_req = 1'b1;
      step(1);
      checks++; if (ram_we[0] !== 1'b1) begin
         errors++; $display("FAIL mid_issue_we: %b, want 1", ram_we[0]); end
      rst = 1'b1;
      #1;
      checks++; if ({ram_we[0], busy[0], owner[0], ram_addr[0], ram_din[0]} !== {1'b0, 1'b0, 1'b1, 10'h0, 32'h0}) begin
         errors++; $display("FAIL mid_reset: we=%b busy=%b own=%b addr=%h din=%h, want 0 0 1 0 0",
                            ram_we[0], busy[0], owner[0], ram_addr[0], ram_din[0]); end
      m0_req = 1'b0;
      step(1);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(1);
         checks++; if (m0_ready[0] !== 1'b0) begin
            errors++; $display("FAIL mid_no_ready[%0d]: %b, want 0", i, m0_ready[0]); end
      end
      m1_we = 1'b0; m1_addr = 10'h033; m1_req = 1'b1;
      step(1);
      m1_req = 1'b0;
      step(3);
      checks++; if ({m1_ready[0], m1_rdata[0]} !== {1'b1, 32'h55AA55AA}) begin
         errors++; $display("FAIL mid_after: rdy=%b data=%h, want 1 55aa55aa", m1_ready[0], m1_rdata[0]); end
      step(2);
   endtask

   task automatic test_addr_wrap();
      logic [11:0] wide;
      do_reset();
      xact(1'b0, 1'b1, 10'h3FF, 32'h0BADCAFE);
      wide = 12'h7FF;
      m0_we = 1'b0; m0_addr = wide[9:0]; m0_req = 1'b1;
      step(1);
      m0_req = 1'b0;
      checks++; if (ram_addr[0] !== 10'h3FF) begin
         errors++; $display("FAIL wrap_addr: %h, want 3ff", ram_addr[0]); end
      step(3);
      checks++; if ({m0_ready[0], m0_rdata[0]} !== {1'b1, 32'h0BADCAFE}) begin
         errors++; $display("FAIL wrap_data: rdy=%b data=%h, want 1 0badcafe", m0_ready[0], m0_rdata[0]); end
      step(2);
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_contention();
      test_withdraw();
      test_reset_midop();
      test_addr_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
